// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with range check and writeback handshake
module load_store_unit #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [15:0] req_base,
  input  logic [5:0]  req_offset,
  input  logic [15:0] req_wdata,
  input  logic [2:0]  req_rd,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  output logic        mem_read,
  input  logic [15:0] mem_read_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_is_load,
  output logic [2:0]  wb_rd,
  output logic [15:0] wb_data,
  output logic        wb_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] wb_data_q;
  logic [2:0]  wb_rd_q;
  logic        wb_is_load_q;
  logic        wb_fault_q;
  logic        wb_valid_q;

  // Effective address wraps at 16 bits; anything at or beyond DEPTH is a fault.
  logic [15:0] ea_d;
  logic        fault_d;

  assign ea_d    = req_base + {{10{req_offset[5]}}, req_offset};
  assign fault_d = (ea_d >= 16'(DEPTH));

  // Strobes are decoded from state so an async reset drops them without waiting for an edge.
  assign mem_write_en = (state_q == ACCESS) && !wb_is_load_q && !wb_fault_q;
  assign mem_read     = (state_q == ACCESS) &&  wb_is_load_q && !wb_fault_q;
  assign req_ready    = (state_q == IDLE);

  assign mem_access_addr = addr_q;
  assign mem_write_data  = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_is_load      = wb_is_load_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign wb_fault        = wb_fault_q;

  // Request/access/response sequencer; all writeback fields are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_is_load_q <= 1'b0;
      wb_fault_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wb_is_load_q <= !req_is_store;
            wb_rd_q      <= req_rd;
            addr_q       <= ea_d;
            wdata_q      <= req_wdata;
            wb_fault_q   <= fault_d;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          // Stores and faulted accesses return zero data.
          wb_data_q  <= (wb_is_load_q && !wb_fault_q) ? mem_read_data : 16'h0000;
          wb_valid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          wb_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [15:0] req_base;
  logic [5:0]  req_offset;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_is_load;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_fault;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  rd;
    logic [15:0] data;
    logic        fault;
  } resp_t;

  resp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [15:0] last_wr_addr = '0;
  int last_accept = 0;
  int prev_accept = 0;

  logic [15:0] mem [8];
  logic        mem_loaded = 1'b0;

  load_store_unit #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_load(wb_is_load),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory model: word i starts as 0x1000+i, combinational read.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'h1000 + 16'(i);
      mem_loaded <= 1'b1;
    end else if (mem_write_en) begin
      mem[mem_access_addr[2:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_access_addr[2:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: counts pulses and flags simultaneous read/write.
  always @(negedge clk) begin
    if (mem_write_en) begin
      wr_cnt++;
      last_wr_addr = mem_access_addr;
    end
    if (mem_read) rd_cnt++;
    if (mem_write_en || mem_read) check("strobe_exclusive", {31'd0, mem_write_en & mem_read}, 32'd0);
  end

  // Writeback monitor: pops the scoreboard on every completion handshake.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("wb_is_load", {31'd0, wb_is_load}, {31'd0, e.is_load});
        check("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
        check("wb_data", {16'd0, wb_data}, {16'd0, e.data});
        check("wb_fault", {31'd0, wb_fault}, {31'd0, e.fault});
      end
    end
  end

  task automatic issue(input logic st, input logic [15:0] base, input logic [5:0] off,
                       input logic [15:0] wd, input logic [2:0] rd,
                       input logic [15:0] exp_ea, input logic [15:0] exp_data, input logic exp_fault);
    resp_t e;
    bit ok;
    e.is_load = !st;
    e.rd      = rd;
    e.data    = exp_data;
    e.fault   = exp_fault;
    @(posedge clk);
    #1;
    req_is_store = st;
    req_base     = base;
    req_offset   = off;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    sb.push_back(e);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    if (!ok) check("req_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    prev_accept = last_accept;
    last_accept = cyc;
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("access_addr", {16'd0, mem_access_addr}, {16'd0, exp_ea});
    check("access_we", {31'd0, mem_write_en}, {31'd0, st & !exp_fault});
    check("access_re", {31'd0, mem_read}, {31'd0, !st & !exp_fault});
    check("access_no_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    check("resp_valid", {31'd0, wb_valid}, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) ok = 1;
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0;
    int r0;
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    int r0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_base = '0;
    req_offset = '0;
    req_wdata = '0;
    req_rd = '0;
    wb_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_data", {16'd0, wb_data}, 32'd0);
    check("rst_addr", {16'd0, mem_access_addr}, 32'd0);
    check("rst_we", {31'd0, mem_write_en}, 32'd0);
    rst_n = 1'b1;

    // Store then load through word 5.
    w0 = wr_cnt;
    issue(1'b1, 16'd3, 6'd2, 16'hBEEF, 3'd1, 16'd5, 16'h0000, 1'b0);
    drain();
    check("store_wr_pulses", wr_cnt - w0, 32'd1);
    check("store_wr_addr", {16'd0, last_wr_addr}, 32'd5);
    check("store_mem5", {16'd0, mem[5]}, 32'hBEEF);
    issue(1'b0, 16'd5, 6'd0, 16'h0000, 3'd4, 16'd5, 16'hBEEF, 1'b0);
    drain();

    // Negative offset 7 + (-7) = 0.
    issue(1'b0, 16'd7, 6'b111001, 16'h0000, 3'd2, 16'd0, 16'h1000, 1'b0);
    drain();

    // Faults: store beyond depth, load wrapping to 0xFFFF.
    w0 = wr_cnt;
    r0 = rd_cnt;
    issue(1'b1, 16'd6, 6'd2, 16'h1234, 3'd6, 16'd8, 16'h0000, 1'b1);
    drain();
    check("fault_no_write", wr_cnt - w0, 32'd0);
    check("fault_mem0", {16'd0, mem[0]}, 32'h1000);
    issue(1'b0, 16'h0002, 6'b111101, 16'h0000, 3'd7, 16'hFFFF, 16'h0000, 1'b1);
    drain();
    check("fault_no_read", rd_cnt - r0, 32'd0);

    // Backpressure with a pending request behind it.
    wb_ready = 1'b0;
    issue(1'b0, 16'd1, 6'd0, 16'h0000, 3'd3, 16'd1, 16'h1001, 1'b0);
    req_is_store = 1'b0;
    req_base = 16'd2;
    req_offset = 6'd0;
    req_rd = 3'd5;
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", {31'd0, wb_valid}, 32'd1);
      check("bp_data", {16'd0, wb_data}, 32'h1001);
      check("bp_rd", {29'd0, wb_rd}, 32'd3);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    sb.push_back('{is_load: 1'b1, rd: 3'd5, data: 16'h1002, fault: 1'b0});
    @(negedge clk);
    @(negedge clk);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    drain();

    // Back-to-back loads: one acceptance every 3 cycles.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 16'(i), 6'd0, 16'h0000, 3'(i), 16'(i), 16'h1000 + 16'(i), 1'b0);
      if (i > 0) check("b2b_interval", last_accept - prev_accept, 32'd3);
    end
    drain();

    // Async reset during a store access to word 2.
    @(posedge clk);
    #1;
    req_is_store = 1'b1;
    req_base = 16'd2;
    req_offset = 6'd0;
    req_wdata = 16'hDEAD;
    req_rd = 3'd1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_access_we_before", {31'd0, mem_write_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_access_we_after", {31'd0, mem_write_en}, 32'd0);
    check("rst_access_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_access_addr", {16'd0, mem_access_addr}, 32'd0);
    check("rst_access_wdata", {16'd0, mem_write_data}, 32'd0);
    check("rst_access_rd", {29'd0, wb_rd}, 32'd0);
    check("rst_access_fault", {31'd0, wb_fault}, 32'd0);
    check("rst_access_is_load", {31'd0, wb_is_load}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_access_mem2", {16'd0, mem[2]}, 32'h1002);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_access_req_ready", {31'd0, req_ready}, 32'd1);
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
